sync_mod_counter: RTL and testbench
===================================

Name: sync_mod_counter

Overview:
- Parametrised synchronous up/down counter. Next generation of the team's 4-bit DFF ripple counter.
- All bits switch on the single `clk` edge: no rippled clocks, no cumulative skew.
- Adds programmable modulus, direction, enable, synchronous clear and load, wrap/saturate mode, and cascade outputs.
- Used as a building block for timers, dividers and address generators.

Parameters:
- WIDTH, 4: counter width in bits; legal range 1..32.
- MODULUS, 16: count range 0..MODULUS-1; legal range 2..2**WIDTH (elaboration error outside this).
- SATURATE, 0: 0 = wrap at the bounds; 1 = hold at the bounds.
- RESET_VAL, 0: value loaded by `rst`; must be < MODULUS.

Ports:
- clk  in  1  single clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; also acts as the cascade carry-in.
- up_dn  in  1  1 = count up, 0 = count down.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  value to load.
- q  out  WIDTH  current count.
- tc  out  1  terminal count, combinational: en & (up_dn ? q==MODULUS-1 : q==0).
- wrap  out  1  registered 1-cycle pulse, high in the cycle after a wrap.
- sat  out  1  registered level; high while held at a bound in SATURATE=1.

Behaviour:
- Reset: `rst` high, asynchronously -> q=RESET_VAL, wrap=0, sat=0. Outputs hold while `rst` is high. The first update is on the first rising `clk` after deassertion.
- Per-edge priority, highest first: clr > load > en.
- clr: q<=0, wrap<=0, sat<=0.
- load:
  - q <= load_val when load_val < MODULUS.
  - q <= MODULUS-1 otherwise (clamp).
  - wrap<=0. sat<=0 (recomputed on later counting).
- en=1, up_dn=1:
  - q<MODULUS-1 -> q+1.
  - q==MODULUS-1 -> SATURATE=0: q<=0, wrap<=1. SATURATE=1: q holds, sat<=1.
- en=1, up_dn=0:
  - q>0 -> q-1.
  - q==0 -> SATURATE=0: q<=MODULUS-1, wrap<=1. SATURATE=1: q holds, sat<=1.
- en=0: q holds, wrap<=0, sat holds.
- sat clears on any enabled step that moves q, and on clr or load.
- Latency: q updates 1 cycle after the qualifying edge. tc is a same-cycle combinational look-ahead. wrap asserts on the edge that performs the wrap, so it is high during the following cycle.
- Cascading: tc of stage N drives en of stage N+1. Every stage shares `clk` and `up_dn`.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - The next-value compare uses the explicit bound, not overflow, so a non-power-of-2 MODULUS wraps exactly.
  - MODULUS==2**WIDTH: the bound is all-ones.
- Simultaneous events:
  - clr+load -> clear wins.
  - load+en -> load wins; the count is ignored for that cycle.
  - up_dn changing mid-count takes effect on the same edge.
- Direction reversal at a bound in SATURATE=1 moves q off the bound and drops sat on that edge.
- Reset mid-operation aborts immediately; no partial state survives.

Decomposition:
- Shared package `counter_pkg`:
  - Direction constants CNT_UP=1, CNT_DN=0.
  - Mode constants MODE_WRAP=0, MODE_SAT=1.
  - Function `clog2` used by instantiating blocks to size WIDTH from MODULUS.
- Sub-module `cnt_next_val`: combinational next-state/flag logic (q, controls -> q_nxt, wrap_nxt, sat_nxt).
- The top level holds only the async-reset registers and the tc decode.

Test Plan:
- WIDTH=4, MODULUS=10, wrap mode, en=1, up_dn=1 from reset -> q: 0,1,…,9,0. wrap high exactly 1 cycle, after 9->0. tc high while q==9.
- Same configuration, up_dn=0 from q=0 -> q=9, wrap pulse. Then 8,7…
- SATURATE=1, load_val=13 with MODULUS=10 -> q=9 (clamp). Count up 3 cycles -> q stays 9, sat=1. Then up_dn=0 -> q=8, sat=0.
- clr, load (load_val=5) and en asserted together at q=3 -> q=0. load+en only -> q=5, not 6.
- Assert rst asynchronously between edges at q=7, RESET_VAL=2 -> q=2 immediately with no clock. Release between edges -> counting resumes from 2 on the next edge.
- Two instances cascaded (low tc -> high en), WIDTH=4, MODULUS=16 -> 256 cycles give combined value 0x00..0xFF and back to 0x00. High-stage wrap pulses once.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and sizing helper for the counter family
package counter_pkg;

  // Direction encoding on up_dn
  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  // Bound behaviour selected by the SATURATE parameter
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Bits needed to hold 0..value-1; never less than one bit
  function automatic int clog2(input longint value);
    longint v;
    int     r;
    v = value - 1;
    r = 0;
    for (int i = 0; i < 64; i++) begin
      if (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cnt_next_val.sv
// rtl/cnt_next_val.sv - combinational next count and flag decode
module cnt_next_val
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter int     SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] q,
  input  logic             sat,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q_nxt,
  output logic             wrap_nxt,
  output logic             sat_nxt
);

  // Explicit upper bound; all-ones when MODULUS fills the width
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  // Priority clr > load > en; wrap is a pulse, sat a held level
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    sat_nxt  = sat;
    if (clr) begin
      q_nxt   = '0;
      sat_nxt = 1'b0;
    end else if (load) begin
      q_nxt   = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      sat_nxt = 1'b0;
    end else if (en) begin
      if (up_dn == CNT_UP) begin
        if (q >= MAX_VAL) begin
          if (SATURATE == MODE_SAT) begin
            sat_nxt = 1'b1;
          end else begin
            q_nxt    = '0;
            wrap_nxt = 1'b1;
          end
        end else begin
          q_nxt   = q + ONE;
          sat_nxt = 1'b0;
        end
      end else begin
        if (q == '0) begin
          if (SATURATE == MODE_SAT) begin
            sat_nxt = 1'b1;
          end else begin
            q_nxt    = MAX_VAL;
            wrap_nxt = 1'b1;
          end
        end else begin
          q_nxt   = q - ONE;
          sat_nxt = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sync_mod_counter.sv
// rtl/sync_mod_counter.sv - synchronous modulus up/down counter with cascade outputs
module sync_mod_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH     = 4,
  parameter longint MODULUS   = 16,
  parameter int     SATURATE  = MODE_WRAP,
  parameter longint RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sync_mod_counter: WIDTH must be 1..32");
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("sync_mod_counter: MODULUS must be 2..2**WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $error("sync_mod_counter: RESET_VAL must be below MODULUS");
  end

  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             sat_nxt;

  cnt_next_val #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next (
    .q        (q),
    .sat      (sat),
    .en       (en),
    .up_dn    (up_dn),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .q_nxt    (q_nxt),
    .wrap_nxt (wrap_nxt),
    .sat_nxt  (sat_nxt)
  );

  // State registers; reset aborts any operation immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= RST_Q;
      wrap <= 1'b0;
      sat  <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
      sat  <= sat_nxt;
    end
  end

  // Same-cycle look-ahead used as carry-in of the next stage
  always_comb begin
    tc = en & ((up_dn == CNT_UP) ? (q == MAX_VAL) : (q == '0));
  end

endmodule

// File: tb/tb_sync_mod_counter.sv
// tb/tb_sync_mod_counter.sv - scoreboard bench for sync_mod_counter
module tb_sync_mod_counter;
  import counter_pkg::*;

  localparam int W10 = clog2(10);
  localparam int W16 = clog2(16);

  typedef enum int {S_QA, S_WA, S_QB, S_SB, S_WB, S_QC, S_WHI} sel_t;
  typedef struct {
    string       tag;
    sel_t        sel;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic rst_b = 1'b1;

  // Wrap-mode instance, MODULUS 10
  logic en_a = 0, up_a = 0, clr_a = 0, load_a = 0;
  logic [W10-1:0] lv_a = '0;
  logic [W10-1:0] q_a;
  logic tc_a, wrap_a, sat_a;

  // Saturating instance, MODULUS 10, RESET_VAL 2
  logic en_b = 0, up_b = 0, clr_b = 0, load_b = 0;
  logic [W10-1:0] lv_b = '0;
  logic [W10-1:0] q_b;
  logic tc_b, wrap_b, sat_b;

  // Two cascaded 4-bit full-range stages
  logic en_c = 0, up_c = 0;
  logic zero_c = 1'b0;
  logic [W16-1:0] zv_c = '0;
  logic [W16-1:0] q_lo, q_hi;
  logic tc_lo, tc_hi, wrap_lo, wrap_hi, sat_lo, sat_hi;

  sync_mod_counter #(.WIDTH(W10), .MODULUS(10), .SATURATE(MODE_WRAP), .RESET_VAL(0)) u_a (
    .clk(clk), .rst(rst), .en(en_a), .up_dn(up_a), .clr(clr_a), .load(load_a),
    .load_val(lv_a), .q(q_a), .tc(tc_a), .wrap(wrap_a), .sat(sat_a));

  sync_mod_counter #(.WIDTH(W10), .MODULUS(10), .SATURATE(MODE_SAT), .RESET_VAL(2)) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .up_dn(up_b), .clr(clr_b), .load(load_b),
    .load_val(lv_b), .q(q_b), .tc(tc_b), .wrap(wrap_b), .sat(sat_b));

  sync_mod_counter #(.WIDTH(W16), .MODULUS(16), .SATURATE(MODE_WRAP), .RESET_VAL(0)) u_lo (
    .clk(clk), .rst(rst), .en(en_c), .up_dn(up_c), .clr(zero_c), .load(zero_c),
    .load_val(zv_c), .q(q_lo), .tc(tc_lo), .wrap(wrap_lo), .sat(sat_lo));

  sync_mod_counter #(.WIDTH(W16), .MODULUS(16), .SATURATE(MODE_WRAP), .RESET_VAL(0)) u_hi (
    .clk(clk), .rst(rst), .en(tc_lo), .up_dn(up_c), .clr(zero_c), .load(zero_c),
    .load_val(zv_c), .q(q_hi), .tc(tc_hi), .wrap(wrap_hi), .sat(sat_hi));

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  function automatic logic [31:0] observe(input sel_t s);
    case (s)
      S_QA:    return 32'(q_a);
      S_WA:    return 32'(wrap_a);
      S_QB:    return 32'(q_b);
      S_SB:    return 32'(sat_b);
      S_WB:    return 32'(wrap_b);
      S_QC:    return 32'({q_hi, q_lo});
      default: return 32'(wrap_hi);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic expect_next(input string tag, input sel_t s, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.val = v;
    sb.push_back(e);
  endtask

  // Advance one edge, then drain the scoreboard against the registered outputs
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.val);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, held across an edge
    @(posedge clk);
    #1;
    check("rst_qa", 32'(q_a), 0);
    check("rst_wa", 32'(wrap_a), 0);
    check("rst_qb", 32'(q_b), 2);
    check("rst_sb", 32'(sat_b), 0);
    check("rst_qc", 32'({q_hi, q_lo}), 0);
    rst = 1'b0;
    rst_b = 1'b0;

    // Wrap mode counting up 0..9,0
    en_a = 1; up_a = 1;
    for (int i = 0; i < 10; i++) begin
      #1 check("up_tc", 32'(tc_a), (i == 9) ? 1 : 0);
      expect_next("up_q", S_QA, (i + 1) % 10);
      expect_next("up_wrap", S_WA, (i == 9) ? 1 : 0);
      tick();
    end
    en_a = 0;
    #1 check("tc_en0", 32'(tc_a), 0);
    expect_next("hold_q", S_QA, 0);
    expect_next("wrap_1cyc", S_WA, 0);
    tick();

    // Down from 0 wraps to 9, then 8..3
    en_a = 1; up_a = 0;
    #1 check("dn_tc0", 32'(tc_a), 1);
    expect_next("dn_wrapq", S_QA, 9);
    expect_next("dn_wrap", S_WA, 1);
    tick();
    for (int v = 8; v >= 3; v--) begin
      expect_next("dn_q", S_QA, v);
      expect_next("dn_nowrap", S_WA, 0);
      tick();
    end

    // clr + load + en at q=3 -> clear wins
    clr_a = 1; load_a = 1; lv_a = 5; up_a = 1;
    expect_next("clr_wins", S_QA, 0);
    tick();
    clr_a = 0;
    expect_next("load_wins", S_QA, 5);
    tick();
    lv_a = 12;
    expect_next("load_clamp_a", S_QA, 9);
    expect_next("load_nowrap", S_WA, 0);
    tick();
    load_a = 0; en_a = 0;
    #1 check("tc_dis_at_max", 32'(tc_a), 0);

    // Saturating instance: clamp, hold at bound, reverse off bound
    load_b = 1; lv_b = 13;
    expect_next("b_clamp", S_QB, 9);
    expect_next("b_clamp_sat", S_SB, 0);
    tick();
    load_b = 0; en_b = 1; up_b = 1;
    #1 check("b_tc_max", 32'(tc_b), 1);
    for (int i = 0; i < 3; i++) begin
      expect_next("b_hold_q", S_QB, 9);
      expect_next("b_sat", S_SB, 1);
      expect_next("b_nowrap", S_WB, 0);
      tick();
    end
    up_b = 0;
    expect_next("b_rev_q", S_QB, 8);
    expect_next("b_rev_sat", S_SB, 0);
    tick();
    load_b = 1; lv_b = 0;
    expect_next("b_load0", S_QB, 0);
    tick();
    load_b = 0;
    expect_next("b_lo_hold", S_QB, 0);
    expect_next("b_lo_sat", S_SB, 1);
    tick();
    en_b = 0;
    expect_next("b_sat_keeps", S_SB, 1);
    tick();
    clr_b = 1;
    expect_next("b_clr_sat", S_SB, 0);
    tick();
    clr_b = 0; load_b = 1; lv_b = 7;
    expect_next("b_load7", S_QB, 7);
    tick();
    load_b = 0; en_b = 1; up_b = 1;

    // Asynchronous reset between edges
    #2 rst_b = 1'b1;
    #1;
    check("b_async_q", 32'(q_b), 2);
    check("b_async_sat", 32'(sat_b), 0);
    expect_next("b_rst_hold", S_QB, 2);
    tick();
    rst_b = 1'b0;
    expect_next("b_resume", S_QB, 3);
    tick();
    expect_next("b_resume2", S_QB, 4);
    tick();
    en_b = 0;

    // Cascade: 256 edges walk 0x00..0xFF and back to 0x00
    en_c = 1; up_c = 1;
    for (int i = 0; i < 256; i++) begin
      expect_next("casc_q", S_QC, (i + 1) % 256);
      expect_next("casc_whi", S_WHI, (i == 255) ? 1 : 0);
      tick();
    end
    up_c = 0;
    #1 check("casc_tchi_dn", 32'(tc_hi), 1);
    expect_next("casc_dn_ff", S_QC, 8'hFF);
    expect_next("casc_dn_whi", S_WHI, 1);
    tick();
    expect_next("casc_dn_fe", S_QC, 8'hFE);
    expect_next("casc_dn_whi0", S_WHI, 0);
    tick();
    en_c = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
